// File: rtl/button_event_decoder.sv
// Turns one debounced switch level into registered single-cycle user events:
// press, release, click, double-click and long-press.
module button_event_decoder #(
    parameter int TICK_CYCLES  = 500000,
    parameter int LONG_TICKS   = 200,
    parameter int DCLICK_TICKS = 60
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_db,
    output logic o_held,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_dbl_click,
    output logic o_long_press
);

    localparam int MAX_TICKS = (LONG_TICKS > DCLICK_TICKS) ? LONG_TICKS : DCLICK_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int PRE_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_TICKS);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DOWN1 = 3'd1,
        S_LONG  = 3'd2,
        S_UP1   = 3'd3,
        S_DOWN2 = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_db_q;
    logic [PRE_W-1:0]   r_presc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_press;
    logic               r_release;
    logic               r_click;
    logic               r_dbl_click;
    logic               r_long_press;

    logic               w_rise;
    logic               w_fall;
    logic               w_tick;
    logic               w_click_nx;
    logic               w_dbl_nx;
    logic               w_long_nx;

    assign w_rise = i_db & ~r_db_q;
    assign w_fall = ~i_db & r_db_q;
    assign w_tick = (r_presc == PRE_LAST);

    // Free-running prescaler; deliberately not restarted by button activity.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_state_nx != r_state) begin
            r_cnt <= '0;
        end else if (w_tick && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Edges are tested before ticks, so an edge always wins over a timeout.
    always_comb begin
        w_state_nx = r_state;
        w_click_nx = 1'b0;
        w_dbl_nx   = 1'b0;
        w_long_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nx = S_DOWN1;
                end
            end
            S_DOWN1: begin
                if (w_fall) begin
                    w_state_nx = S_UP1;
                end else if (w_tick && (r_cnt == LONG_LAST)) begin
                    w_long_nx  = 1'b1;
                    w_state_nx = S_LONG;
                end
            end
            S_LONG: begin
                if (w_fall) begin
                    w_state_nx = S_IDLE;
                end
            end
            S_UP1: begin
                if (w_rise) begin
                    w_state_nx = S_DOWN2;
                end else if (w_tick && (r_cnt == DCLICK_LAST)) begin
                    w_click_nx = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            S_DOWN2: begin
                if (w_fall) begin
                    w_dbl_nx   = 1'b1;
                    w_state_nx = S_IDLE;
                end else if (w_tick && (r_cnt == LONG_LAST)) begin
                    w_long_nx  = 1'b1;
                    w_state_nx = S_LONG;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_db_q       <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_click      <= 1'b0;
            r_dbl_click  <= 1'b0;
            r_long_press <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_db_q       <= i_db;
            r_press      <= w_rise;
            r_release    <= w_fall;
            r_click      <= w_click_nx;
            r_dbl_click  <= w_dbl_nx;
            r_long_press <= w_long_nx;
        end
    end

    assign o_held       = r_db_q;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_click      = r_click;
    assign o_dbl_click  = r_dbl_click;
    assign o_long_press = r_long_press;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: gesture-level reference model feeding a
// scoreboard queue, directed gesture scenarios, then random button activity.
module tb_button_event_decoder;

    localparam int TICK   = 4;
    localparam int LONG   = 5;
    localparam int DCLICK = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic db  = 1'b0;
    logic held, press, rel, click, dbl, lng;

    button_event_decoder #(
        .TICK_CYCLES (TICK),
        .LONG_TICKS  (LONG),
        .DCLICK_TICKS(DCLICK)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_db        (db),
        .o_held      (held),
        .o_press     (press),
        .o_release   (rel),
        .o_click     (click),
        .o_dbl_click (dbl),
        .o_long_press(lng)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    p, r, c, d, l;
        bit    chk;
    } scen_t;

    logic [5:0] exp_q[$];
    scen_t      scen_q[$];
    int         edge_k = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    // Reference model: a gesture is described by how many presses it has
    // collected, whether the button is currently down, whether it already
    // became a long hold, and how many ticks have elapsed in the current phase.
    initial begin : model
        int  presses, ticks;
        bit  down, long_done, prev, tick, rise, fall;
        bit  e_click, e_dbl, e_long;
        presses = 0; ticks = 0; down = 0; long_done = 0; prev = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                presses = 0; ticks = 0; down = 0; long_done = 0; prev = 0;
                edge_k = 0;
                exp_q.delete();
            end else begin
                tick = ((edge_k % TICK) == TICK - 1);
                rise = db && !prev;
                fall = !db && prev;
                e_click = 0; e_dbl = 0; e_long = 0;
                if (long_done) begin
                    if (fall) begin
                        long_done = 0; presses = 0; down = 0;
                    end
                end else if (presses == 0) begin
                    if (rise) begin
                        presses = 1; down = 1; ticks = 0;
                    end
                end else if (down) begin
                    if (fall) begin
                        down = 0; ticks = 0;
                        if (presses == 2) begin
                            e_dbl = 1; presses = 0;
                        end
                    end else if (tick) begin
                        if (ticks == LONG - 1) begin
                            e_long = 1; long_done = 1; ticks = 0;
                        end else begin
                            ticks++;
                        end
                    end
                end else begin
                    if (rise) begin
                        presses = 2; down = 1; ticks = 0;
                    end else if (tick) begin
                        if (ticks == DCLICK - 1) begin
                            e_click = 1; presses = 0;
                        end else begin
                            ticks++;
                        end
                    end
                end
                exp_q.push_back({db, rise, fall, e_click, e_dbl, e_long});
                prev = db;
                edge_k++;
            end
        end
    end

    task automatic check_vec(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t held/press/rel/click/dbl/long got=%b want=%b", nm, $time, act, exp);
        end
    endtask

    task automatic check_cnt(input string nm, input string what, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s %s count got=%0d want=%0d", nm, what, act, exp);
        end
    endtask

    // Monitor: compares every cycle against the model and tallies pulses per scenario.
    initial begin : monitor
        bit         rst_prev;
        int         tp, tr, tc, td, tl;
        int         bp, br, bc, bd, bl;
        logic [5:0] e;
        scen_t      s;
        rst_prev = 1;
        tp = 0; tr = 0; tc = 0; td = 0; tl = 0;
        bp = 0; br = 0; bc = 0; bd = 0; bl = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst && !rst_prev) begin
                rst_prev = 1;
                #1;
                check_vec("reset_async", {held, press, rel, click, dbl, lng}, 6'b0);
            end else if (rst) begin
                check_vec("in_reset", {held, press, rel, click, dbl, lng}, 6'b0);
            end else begin
                rst_prev = 0;
                while (scen_q.size() > 0) begin
                    s = scen_q.pop_front();
                    if (s.chk) begin
                        check_cnt(s.name, "press",      tp - bp, s.p);
                        check_cnt(s.name, "release",    tr - br, s.r);
                        check_cnt(s.name, "click",      tc - bc, s.c);
                        check_cnt(s.name, "dbl_click",  td - bd, s.d);
                        check_cnt(s.name, "long_press", tl - bl, s.l);
                    end
                    bp = tp; br = tr; bc = tc; bd = td; bl = tl;
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_vec("cycle", {held, press, rel, click, dbl, lng}, e);
                    tp += int'(press); tr += int'(rel); tc += int'(click);
                    td += int'(dbl);   tl += int'(lng);
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        db = v;
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        db  = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #2;
        end
        rst = 1'b0;
    endtask

    task automatic mark();
        scen_t s;
        s.name = "mark"; s.chk = 0;
        s.p = 0; s.r = 0; s.c = 0; s.d = 0; s.l = 0;
        scen_q.push_back(s);
    endtask

    task automatic expect_counts(input string nm, input int p, input int r,
                                 input int c, input int d, input int l);
        scen_t s;
        s.name = nm; s.chk = 1;
        s.p = p; s.r = r; s.c = c; s.d = d; s.l = l;
        scen_q.push_back(s);
    endtask

    initial begin : driver
        @(negedge clk);
        #2;
        do_reset();
        drive(0, 3);

        mark(); drive(1, 8); drive(0, 20);
        expect_counts("single_click", 1, 1, 1, 0, 0);

        mark(); drive(1, 40); drive(0, 20);
        expect_counts("long_hold", 1, 1, 0, 0, 1);

        mark(); drive(1, 6); drive(0, 4); drive(1, 6); drive(0, 20);
        expect_counts("double_click", 2, 2, 0, 1, 0);

        mark(); drive(1, 6); drive(0, 4); drive(1, 40); drive(0, 20);
        expect_counts("long_from_down2", 2, 2, 0, 0, 1);

        mark(); drive(1, 3); do_reset(); drive(0, 20);
        expect_counts("reset_in_down1", 1, 0, 0, 0, 0);
        mark(); drive(1, 6); drive(0, 3); do_reset(); drive(0, 20);
        expect_counts("reset_in_up1", 1, 1, 0, 0, 0);
        mark(); drive(1, 6); drive(0, 20);
        expect_counts("press_after_reset", 1, 1, 1, 0, 0);

        // Align the rise to a tick edge so the fall lands on the LONG-th tick.
        while ((edge_k % TICK) != TICK - 1) drive(0, 1);
        mark(); drive(1, LONG * TICK); drive(0, 20);
        expect_counts("fall_beats_tick", 1, 1, 1, 0, 0);

        mark();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            else drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 28)));
        end
        drive(0, 30);
        mark();
        drive(0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
